// File: rtl/exc_request_unit.sv
// Exception request unit: syncs/edge-latches IRQs and arbitrates decoder traps into CP0 exception/eret strobes.
// exception/cause/irq_id/eret are combinational (zero latency); IRQ edge to pending is SYNC_STAGES+1 cycles.
// stall holds off fire/eret/pending-clear; `define IRQ_MASK_EN adds a per-line mask register (mask_we/mask_wdata).
module exc_request_unit #(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [4:0]  CAUSE_INT   = 5'd0,
  parameter logic [4:0]  CAUSE_SYS   = 5'd8,
  parameter logic [4:0]  CAUSE_BRK   = 5'd9,
  parameter logic [4:0]  CAUSE_TEQ   = 5'd13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               syscall,
  input  logic               brk,
  input  logic               teq_trap,
  input  logic               eret_in,
  input  logic               stall,
  input  logic               status_ie,
`ifdef IRQ_MASK_EN
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
`endif
  output logic               exception,
  output logic               eret,
  output logic [4:0]         cause,
  output logic [2:0]         irq_id,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               in_handler,
  output logic               drop_err
);

  typedef enum logic {IDLE = 1'b0, HANDLER = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] eff_pending;
  logic [NUM_IRQ-1:0] irq_sel;
  logic [NUM_IRQ-1:0] irq_clr;
  logic [4:0]         win_cause;
  logic [2:0]         win_id;
  logic               irq_win;
  logic               trap_any;
  logic               fire;
  logic               eret_take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      irq_prev <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      irq_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign irq_edge = sync_q[SYNC_STAGES-1] & ~irq_prev;

`ifdef IRQ_MASK_EN
  logic [NUM_IRQ-1:0] mask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        mask_q <= '1;
    else if (mask_we) mask_q <= mask_wdata;
  end

  // Masking only gates arbitration; masked lines still accumulate pending.
  assign eff_pending = irq_pending & mask_q;
`else
  assign eff_pending = irq_pending;
`endif

  // Fixed priority: teq > syscall > brk > lowest-index IRQ.
  always_comb begin
    win_cause = CAUSE_INT;
    win_id    = '0;
    irq_win   = 1'b0;
    irq_sel   = '0;
    if (teq_trap)     win_cause = CAUSE_TEQ;
    else if (syscall) win_cause = CAUSE_SYS;
    else if (brk)     win_cause = CAUSE_BRK;
    else begin
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
        if (eff_pending[i] && !irq_win) begin
          irq_win    = 1'b1;
          irq_sel[i] = 1'b1;
          win_id     = 3'(i);
        end
      end
    end
  end

  assign trap_any  = syscall | brk | teq_trap;
  // eret_in takes precedence over any simultaneous request.
  assign fire      = (state == IDLE) & ~stall & ~eret_in & status_ie & (trap_any | (|eff_pending));
  assign eret_take = eret_in & ~stall;
  assign irq_clr   = (fire && irq_win) ? irq_sel : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_pending <= '0;
      drop_err    <= 1'b0;
    end else begin
      irq_pending <= (irq_pending & ~irq_clr) | irq_edge;
      if (trap_any && !stall && !eret_in && (!status_ie || state == HANDLER))
        drop_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire)      state_nxt = HANDLER;
      HANDLER: if (eret_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    exception  = 1'b0;
    eret       = 1'b0;
    cause      = '0;
    irq_id     = '0;
    in_handler = (state == HANDLER);
    if (!reset) begin
      exception = fire;
      eret      = eret_take;
      if (fire) begin
        cause  = win_cause;
        irq_id = irq_win ? win_id : 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_exc_request_unit.sv
// Scoreboarded bench for exc_request_unit: expected exception/eret events are queued at drive time, popped on output.
module tb_exc_request_unit;

  typedef struct {
    logic [4:0] cause;
    logic [2:0] id;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  logic       syscall, brk, teq_trap, eret_in, stall, status_ie;
`ifdef IRQ_MASK_EN
  logic       mask_we;
  logic [7:0] mask_wdata;
`endif
  logic       exception, eret;
  logic [4:0] cause;
  logic [2:0] irq_id;
  logic [7:0] irq_pending;
  logic       in_handler, drop_err;

  exp_t exc_q [$];
  bit   eret_q [$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  exc_request_unit dut (
    .clk(clk), .reset(reset), .irq_in(irq_in),
    .syscall(syscall), .brk(brk), .teq_trap(teq_trap), .eret_in(eret_in),
    .stall(stall), .status_ie(status_ie),
`ifdef IRQ_MASK_EN
    .mask_we(mask_we), .mask_wdata(mask_wdata),
`endif
    .exception(exception), .eret(eret), .cause(cause), .irq_id(irq_id),
    .irq_pending(irq_pending), .in_handler(in_handler), .drop_err(drop_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exc(input logic [4:0] c, input logic [2:0] id);
    exp_t e;
    e.cause = c;
    e.id    = id;
    exc_q.push_back(e);
  endtask

  // Output monitor: every DUT strobe must match a queued expectation.
  always @(negedge clk) begin
    if (exception === 1'b1) begin
      if (exc_q.size() == 0) chk("exc_unexpected", 32'(exception), 32'd0);
      else begin
        exp_t e;
        e = exc_q.pop_front();
        chk("exc_cause", 32'(cause), 32'(e.cause));
        chk("exc_irq_id", 32'(irq_id), 32'(e.id));
      end
    end else if (exception !== 1'b0) chk("exc_x", 32'(exception), 32'd0);
    if (eret === 1'b1) begin
      if (eret_q.size() == 0) chk("eret_unexpected", 32'(eret), 32'd0);
      else void'(eret_q.pop_front());
    end else if (eret !== 1'b0) chk("eret_x", 32'(eret), 32'd0);
  end

  initial begin
    reset = 1'b1; irq_in = '0; syscall = 0; brk = 0; teq_trap = 0;
    eret_in = 0; stall = 0; status_ie = 0;
`ifdef IRQ_MASK_EN
    mask_we = 0; mask_wdata = '0;
`endif
    // 1: outputs gated during reset
    syscall = 1; status_ie = 1;
    cyc(2);
    chk("rst_exception", 32'(exception), 32'd0);
    chk("rst_cause", 32'(cause), 32'd0);
    reset = 0; syscall = 0;
    cyc();
    chk("rel_in_handler", 32'(in_handler), 32'd0);
    chk("rel_pending", 32'(irq_pending), 32'd0);
    chk("rel_drop_err", 32'(drop_err), 32'd0);

    // 2: syscall fires same cycle, eret returns to idle
    syscall = 1; push_exc(5'd8, 3'd0);
    cyc();
    syscall = 0;
    chk("t2_in_handler", 32'(in_handler), 32'd1);
    eret_in = 1; eret_q.push_back(1'b1);
    cyc();
    eret_in = 0;
    chk("t2_eret_idle", 32'(in_handler), 32'd0);

    // 3: irq edge -> pending at cycle 3, fires and clears
    irq_in[3] = 1; push_exc(5'd0, 3'd3);
    cyc(2);
    chk("t3_pend_early", 32'(irq_pending), 32'h00);
    cyc();
    chk("t3_pend_c3", 32'(irq_pending), 32'h08);
    cyc();
    chk("t3_pend_clr", 32'(irq_pending), 32'h00);
    chk("t3_in_handler", 32'(in_handler), 32'd1);
    irq_in[3] = 0; eret_in = 1; eret_q.push_back(1'b1);
    cyc();
    eret_in = 0;

    // 4: teq beats brk and pending irq; irq fires the cycle after eret
    status_ie = 0; irq_in[0] = 1;
    cyc(4);
    chk("t4_pend0", 32'(irq_pending), 32'h01);
    status_ie = 1; teq_trap = 1; brk = 1; push_exc(5'd13, 3'd0);
    cyc();
    teq_trap = 0; brk = 0;
    chk("t4_pend_kept", 32'(irq_pending), 32'h01);
    chk("t4_in_handler", 32'(in_handler), 32'd1);
    eret_in = 1; eret_q.push_back(1'b1);
    cyc();
    eret_in = 0; push_exc(5'd0, 3'd0);
    cyc();
    chk("t4_irq_handler", 32'(in_handler), 32'd1);
    cyc(3);
    chk("t4_level_once", 32'(irq_pending), 32'h00);
    irq_in[0] = 0; eret_in = 1; eret_q.push_back(1'b1);
    cyc();
    eret_in = 0;
    chk("t4_no_drop", 32'(drop_err), 32'd0);

    // 5: trap with ie=0 is dropped (sticky); stall holds off an irq
    status_ie = 0; brk = 1;
    cyc();
    brk = 0;
    chk("t5_drop", 32'(drop_err), 32'd1);
    cyc(3);
    chk("t5_drop_sticky", 32'(drop_err), 32'd1);
    irq_in[1] = 1;
    cyc(3);
    stall = 1; status_ie = 1;
    cyc(3);
    chk("t5_stall_pend", 32'(irq_pending), 32'h02);
    chk("t5_stall_idle", 32'(in_handler), 32'd0);
    stall = 0; push_exc(5'd0, 3'd1);
    cyc();
    chk("t5_fired", 32'(in_handler), 32'd1);
    eret_in = 1; stall = 1;
    cyc();
    chk("t5_stall_eret", 32'(in_handler), 32'd1);
    stall = 0; eret_q.push_back(1'b1);
    cyc();
    eret_in = 0; irq_in[1] = 0;
    chk("t5_eret_done", 32'(in_handler), 32'd0);

    // eret in idle still strobes; trap with eret is treated as eret
    eret_in = 1; eret_q.push_back(1'b1);
    cyc();
    chk("idle_eret_state", 32'(in_handler), 32'd0);
    syscall = 1; eret_q.push_back(1'b1);
    cyc();
    eret_in = 0; syscall = 0;
    chk("trap_eret_state", 32'(in_handler), 32'd0);

    // reset mid-handler drops state and pending
    syscall = 1; push_exc(5'd8, 3'd0);
    cyc();
    syscall = 0; irq_in[2] = 1;
    cyc(4);
    chk("mid_pend", 32'(irq_pending), 32'h04);
    reset = 1;
    cyc();
    reset = 0; irq_in = '0;
    cyc();
    chk("mid_rst_handler", 32'(in_handler), 32'd0);
    chk("mid_rst_pend", 32'(irq_pending), 32'h00);
    chk("mid_rst_drop", 32'(drop_err), 32'd0);

`ifdef IRQ_MASK_EN
    // 6: masked line latches but does not fire until unmasked
    mask_we = 1; mask_wdata = 8'hFE;
    cyc();
    mask_we = 0; irq_in[0] = 1;
    cyc(4);
    chk("t6_masked_pend", 32'(irq_pending), 32'h01);
    chk("t6_masked_idle", 32'(in_handler), 32'd0);
    mask_we = 1; mask_wdata = 8'hFF;
    cyc();
    mask_we = 0; push_exc(5'd0, 3'd0);
    cyc();
    chk("t6_unmask_fire", 32'(in_handler), 32'd1);
    irq_in[0] = 0; eret_in = 1; eret_q.push_back(1'b1);
    cyc();
    eret_in = 0;
`endif

    cyc(2);
    chk("exc_q_left", 32'(exc_q.size()), 32'd0);
    chk("eret_q_left", 32'(eret_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
